// File: rtl/rx_word_aligner_if.sv
// rtl/rx_word_aligner_if.sv - stream and status bundle for rx_word_aligner
//
// Purpose: groups the raw GT-side inputs, the realign request, the aligned
// outputs and the statistics outputs of rx_word_aligner into one bundle.
// Signals:
//   realign_i        realignment request (acted on at its rising edge)
//   rx_data_i[15:0]  raw received data
//   rx_k_i[1:0]      raw K flags (bit 1 -> [15:8], bit 0 -> [7:0])
//   rx_data_o[15:0]  aligned data
//   rx_k_o[1:0]      aligned K flags
//   aligned_o        high while locked
//   byte_swap_o      1 when the byte-swap path is selected
//   realign_cnt_o    lock-loss counter (0 unless stats are built)
//   comma_err_cnt_o  wrong-lane comma counter (0 unless stats are built)
// Modports: master drives the raw side, slave is the aligner.
interface rx_word_aligner_if;
  logic        realign_i;
  logic [15:0] rx_data_i;
  logic [1:0]  rx_k_i;
  logic [15:0] rx_data_o;
  logic [1:0]  rx_k_o;
  logic        aligned_o;
  logic        byte_swap_o;
  logic [15:0] realign_cnt_o;
  logic [15:0] comma_err_cnt_o;

  modport master (
    output realign_i, rx_data_i, rx_k_i,
    input  rx_data_o, rx_k_o, aligned_o, byte_swap_o, realign_cnt_o, comma_err_cnt_o
  );

  modport slave (
    input  realign_i, rx_data_i, rx_k_i,
    output rx_data_o, rx_k_o, aligned_o, byte_swap_o, realign_cnt_o, comma_err_cnt_o
  );
endinterface

// File: rtl/rx_word_aligner.sv
// rtl/rx_word_aligner.sv - 16-bit receive word aligner with comma lock FSM
//
// Purpose: locks onto the lane position of the IDLE comma in a 2-byte
// 8b/10b-decoded stream and byte-swaps the stream when the comma arrives in
// the low byte. The output is word aligned with a constant 2-cycle latency;
// aligned_o qualifies it while the FSM is LOCKED.
// Ports:
//   usrclk_i  user clock, the only clock
//   rst_i     asynchronous active-high reset
//   bus       rx_word_aligner_if.slave (raw in, aligned out, status)
// Optional feature: define RX_WORD_ALIGNER_STATS_EN to build the saturating
// lock-loss and wrong-lane comma counters; otherwise those ports read 0.
module rx_word_aligner #(
  parameter logic [15:0] g_IDLE         = 16'hbc95,
  parameter int          g_ACQUIRE_CNT  = 3,
  parameter int          g_LOSS_CNT     = 4,
  parameter int          g_IDLE_TIMEOUT = 1024
) (
  input  logic            usrclk_i,
  input  logic            rst_i,
  rx_word_aligner_if.slave bus
);

  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [7:0]  ACQ_LAST  = 8'(g_ACQUIRE_CNT - 1);
  localparam logic [7:0]  LOSS_LAST = 8'(g_LOSS_CNT - 1);
  localparam logic [15:0] TMO_LAST  = 16'(g_IDLE_TIMEOUT - 1);
  localparam logic [1:0]  LOCK_FROM_HUNT = (g_ACQUIRE_CNT == 1) ? S_LOCKED : S_VERIFY;

  logic [1:0]  state;
  logic        swap;
  logic [7:0]  acq;
  logic [7:0]  loss;
  logic [15:0] tmo;
  logic [15:0] d1;
  logic [1:0]  k1;
  logic [15:0] out_d;
  logic [1:0]  out_k;
  logic        rq1;
  logic        rq2;

  logic lane1_comma;
  logic lane0_comma;
  logic good_comma;
  logic bad_comma;
  logic realign_edge;
  logic loss_hit;
  logic tmo_hit;

  assign lane1_comma = (bus.rx_k_i == 2'b10) && (bus.rx_data_i == g_IDLE);
  assign lane0_comma = (bus.rx_k_i == 2'b01) && (bus.rx_data_i[7:0] == g_IDLE[15:8]);
  assign good_comma  = swap ? lane0_comma : lane1_comma;
  assign bad_comma   = swap ? lane1_comma : lane0_comma;

  // Edge detect works on the registered request, so the action lands one
  // cycle after the request is first sampled.
  assign realign_edge = rq1 & ~rq2;

  assign loss_hit = bad_comma && (loss == LOSS_LAST);
  // Timeout counts every locked cycle that lacks a correct-lane comma.
  assign tmo_hit  = !good_comma && (tmo == TMO_LAST);

  always_ff @(posedge usrclk_i or posedge rst_i) begin
    if (rst_i) begin
      d1    <= '0;
      k1    <= '0;
      out_d <= '0;
      out_k <= '0;
    end else begin
      d1 <= bus.rx_data_i;
      k1 <= bus.rx_k_i;
      // Swap path takes the low byte of the previous word and the high byte
      // of the current one, so both paths see the same 2-cycle latency.
      if (swap) begin
        out_d <= {d1[7:0], bus.rx_data_i[15:8]};
        out_k <= {k1[0], bus.rx_k_i[1]};
      end else begin
        out_d <= d1;
        out_k <= k1;
      end
    end
  end

  always_ff @(posedge usrclk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_HUNT;
      swap  <= 1'b0;
      acq   <= '0;
      loss  <= '0;
      tmo   <= '0;
      rq1   <= 1'b0;
      rq2   <= 1'b0;
    end else begin
      rq1 <= bus.realign_i;
      rq2 <= rq1;
      if (realign_edge) begin
        state <= S_HUNT;
        acq   <= '0;
        loss  <= '0;
        tmo   <= '0;
      end else begin
        case (state)
          S_HUNT: begin
            if (lane1_comma || lane0_comma) begin
              swap  <= lane0_comma;
              acq   <= 8'd1;
              loss  <= '0;
              tmo   <= '0;
              state <= LOCK_FROM_HUNT;
            end
          end
          S_VERIFY: begin
            if (good_comma) begin
              if (acq == ACQ_LAST) begin
                state <= S_LOCKED;
                loss  <= '0;
                tmo   <= '0;
              end else begin
                acq <= acq + 8'd1;
              end
            end else if (bad_comma) begin
              swap <= ~swap;
              acq  <= 8'd1;
            end
          end
          S_LOCKED: begin
            if (loss_hit || tmo_hit) begin
              state <= S_HUNT;
              acq   <= '0;
              loss  <= '0;
              tmo   <= '0;
            end else if (good_comma) begin
              loss <= '0;
              tmo  <= '0;
            end else begin
              if (bad_comma) loss <= loss + 8'd1;
              tmo <= tmo + 16'd1;
            end
          end
          default: begin
            state <= S_HUNT;
            acq   <= '0;
            loss  <= '0;
            tmo   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.rx_data_o   = out_d;
  assign bus.rx_k_o      = out_k;
  assign bus.aligned_o   = (state == S_LOCKED);
  assign bus.byte_swap_o = swap;

`ifdef RX_WORD_ALIGNER_STATS_EN
  logic [15:0] realign_cnt;
  logic [15:0] comma_err_cnt;
  logic        lock_drop;
  logic        err_seen;

  // Any exit from LOCKED, including a realign request, is one lock loss.
  assign lock_drop = (state == S_LOCKED) && (realign_edge || loss_hit || tmo_hit);
  assign err_seen  = (state == S_LOCKED) && bad_comma && !realign_edge;

  always_ff @(posedge usrclk_i or posedge rst_i) begin
    if (rst_i) begin
      realign_cnt   <= '0;
      comma_err_cnt <= '0;
    end else begin
      if (lock_drop && (realign_cnt != 16'hffff))
        realign_cnt <= realign_cnt + 16'd1;
      if (err_seen && (comma_err_cnt != 16'hffff))
        comma_err_cnt <= comma_err_cnt + 16'd1;
    end
  end

  assign bus.realign_cnt_o   = realign_cnt;
  assign bus.comma_err_cnt_o = comma_err_cnt;
`else
  assign bus.realign_cnt_o   = 16'd0;
  assign bus.comma_err_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_rx_word_aligner.sv
// tb/tb_rx_word_aligner.sv - directed self-checking bench for rx_word_aligner
module tb_rx_word_aligner;

`ifdef RX_WORD_ALIGNER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  logic [15:0] prev_d = '0;
  logic [1:0]  prev_k = '0;
  logic        exp_swap = 1'b0;
  logic [17:0] wprev = '0;

  rx_word_aligner_if bus ();

  rx_word_aligner dut (
    .usrclk_i (clk),
    .rst_i    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Aligned reference stream: IDLE (k=10) every p words, timestamps otherwise.
  function automatic logic [17:0] wgen(input int n, input int p);
    logic [15:0] ts;
    ts = 16'(n * 7 + 3);
    if (n % p == 0) return {16'hbc95, 2'b10};
    return {ts, 2'b00};
  endfunction

  // Drive one raw word, clock it, check the output against the latency model.
  task automatic send(input logic [15:0] d, input logic [1:0] k);
    logic [15:0] ed;
    logic [1:0]  ek;
    ed = exp_swap ? {prev_d[7:0], d[15:8]} : prev_d;
    ek = exp_swap ? {prev_k[0], k[1]} : prev_k;
    bus.rx_data_i = d;
    bus.rx_k_i    = k;
    @(posedge clk);
    #1;
    check("data", {16'd0, bus.rx_data_o}, {16'd0, ed});
    check("k", {30'd0, bus.rx_k_o}, {30'd0, ek});
    prev_d = d;
    prev_k = k;
  endtask

  task automatic send_aligned(input int n, input int p);
    logic [17:0] w;
    w = wgen(n, p);
    send(w[17:2], w[1:0]);
  endtask

  // Same reference stream shifted by one byte (comma lands in [7:0], k=01).
  task automatic send_shift(input int n, input int p);
    logic [17:0] w;
    w = wgen(n, p);
    send({wprev[9:2], w[17:10]}, {wprev[0], w[1]});
    wprev = w;
  endtask

  task automatic filler(input int i);
    send(16'(16'h1000 + i), 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.rx_data_i = '0;
    bus.rx_k_i    = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_d = '0;
    prev_k = '0;
    exp_swap = 1'b0;
    wprev = '0;
  endtask

  initial begin
    bus.realign_i = 1'b0;
    bus.rx_data_i = '0;
    bus.rx_k_i    = '0;
    @(posedge clk);
    #1;
    check("rst_data", {16'd0, bus.rx_data_o}, 32'd0);
    check("rst_k", {30'd0, bus.rx_k_o}, 32'd0);
    check("rst_aligned", {31'd0, bus.aligned_o}, 32'd0);
    check("rst_swap", {31'd0, bus.byte_swap_o}, 32'd0);
    check("rst_realign_cnt", {16'd0, bus.realign_cnt_o}, 32'd0);
    check("rst_err_cnt", {16'd0, bus.comma_err_cnt_o}, 32'd0);
    rst = 1'b0;

    // Aligned stream, IDLE every 193 words: lock after the third IDLE.
    for (int n = 0; n < 386; n++) send_aligned(n, 193);
    check("t1_pre_lock", {31'd0, bus.aligned_o}, 32'd0);
    send_aligned(386, 193);
    check("t1_lock", {31'd0, bus.aligned_o}, 32'd1);
    check("t1_swap", {31'd0, bus.byte_swap_o}, 32'd0);
    for (int n = 387; n < 392; n++) send_aligned(n, 193);

    // Byte-shifted stream: lock with swap, output restores original words.
    do_reset();
    send_shift(0, 8);
    exp_swap = 1'b1;
    check("t2_swap_sel", {31'd0, bus.byte_swap_o}, 32'd1);
    for (int n = 1; n < 16; n++) send_shift(n, 8);
    check("t2_pre_lock", {31'd0, bus.aligned_o}, 32'd0);
    send_shift(16, 8);
    check("t2_lock", {31'd0, bus.aligned_o}, 32'd1);
    send_shift(17, 8);
    check("t2_idle_data", {16'd0, bus.rx_data_o}, 32'h0000bc95);
    check("t2_idle_k", {30'd0, bus.rx_k_o}, 32'd2);
    for (int n = 18; n < 25; n++) send_shift(n, 8);
    check("t2_ts_data", {16'd0, bus.rx_data_o}, {16'd0, 16'(23 * 7 + 3)});

    // Four wrong-lane commas while locked drop the lock on the fourth.
    for (int i = 0; i < 3; i++) send(16'hbc95, 2'b10);
    check("t3_after3", {31'd0, bus.aligned_o}, 32'd1);
    send(16'hbc95, 2'b10);
    check("t3_after4", {31'd0, bus.aligned_o}, 32'd0);
    check("t3_realign_cnt", {16'd0, bus.realign_cnt_o}, 32'(STATS * 1));
    check("t3_err_cnt", {16'd0, bus.comma_err_cnt_o}, 32'(STATS * 4));
    check("t3_swap_held", {31'd0, bus.byte_swap_o}, 32'd1);

    // Re-lock on aligned stream, then 1024 idle-free cycles time out.
    send_aligned(0, 8);
    exp_swap = 1'b0;
    for (int n = 1; n <= 16; n++) send_aligned(n, 8);
    check("t4_lock", {31'd0, bus.aligned_o}, 32'd1);
    check("t4_swap", {31'd0, bus.byte_swap_o}, 32'd0);
    for (int i = 1; i < 1024; i++) filler(i);
    check("t4_before_tmo", {31'd0, bus.aligned_o}, 32'd1);
    filler(1024);
    check("t4_tmo", {31'd0, bus.aligned_o}, 32'd0);
    check("t4_realign_cnt", {16'd0, bus.realign_cnt_o}, 32'(STATS * 2));
    send(16'hbc95, 2'b10); filler(1);
    send(16'hbc95, 2'b10); filler(2);
    check("t4_relock_pre", {31'd0, bus.aligned_o}, 32'd0);
    send(16'hbc95, 2'b10);
    check("t4_relock", {31'd0, bus.aligned_o}, 32'd1);

    // Realign pulse while locked: lock drops two cycles later; holding it
    // high does not block re-acquisition.
    bus.realign_i = 1'b1;
    filler(3);
    check("t5_one_cycle", {31'd0, bus.aligned_o}, 32'd1);
    filler(4);
    check("t5_two_cycles", {31'd0, bus.aligned_o}, 32'd0);
    check("t5_realign_cnt", {16'd0, bus.realign_cnt_o}, 32'(STATS * 3));
    send(16'hbc95, 2'b10); filler(5);
    send(16'hbc95, 2'b10); filler(6);
    check("t5_relock_pre", {31'd0, bus.aligned_o}, 32'd0);
    send(16'hbc95, 2'b10);
    check("t5_relock", {31'd0, bus.aligned_o}, 32'd1);
    bus.realign_i = 1'b0;
    filler(7);

    // Reset mid-VERIFY (two shifted commas seen, swap selected).
    do_reset();
    send_shift(0, 8);
    exp_swap = 1'b1;
    for (int n = 1; n <= 9; n++) send_shift(n, 8);
    check("t6_verify_swap", {31'd0, bus.byte_swap_o}, 32'd1);
    check("t6_verify_unaligned", {31'd0, bus.aligned_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_data", {16'd0, bus.rx_data_o}, 32'd0);
    check("t6_rst_k", {30'd0, bus.rx_k_o}, 32'd0);
    check("t6_rst_swap", {31'd0, bus.byte_swap_o}, 32'd0);
    check("t6_rst_aligned", {31'd0, bus.aligned_o}, 32'd0);
    check("t6_rst_realign_cnt", {16'd0, bus.realign_cnt_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_d = '0;
    prev_k = '0;
    exp_swap = 1'b0;
    wprev = '0;
    send_shift(0, 8);
    exp_swap = 1'b1;
    check("t6_first_comma", {31'd0, bus.aligned_o}, 32'd0);
    for (int n = 1; n <= 8; n++) send_shift(n, 8);
    check("t6_second_comma", {31'd0, bus.aligned_o}, 32'd0);
    for (int n = 9; n <= 16; n++) send_shift(n, 8);
    check("t6_third_comma", {31'd0, bus.aligned_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
